// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Byte-to-line UART transmitter. While idle it accepts one byte on a ready
// pulse and shifts it out on UART_TX as 8N1, LSB first. done is high while
// the block is idle and can accept; the upstream drain logic edge-detects it
// to advance its queue head.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : an even-parity bit (XOR of the 8 data bits, taken from the
//               byte at acceptance) is sent between data bit 7 and the stop
//               bit, giving 8E1 frames of 11 bit periods.
//   undefined : plain 8N1 frames of 10 bit periods, no parity state.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per bit period (>= 2)
//
// Ports
//   CLK     in   system clock, all state changes on posedge
//   RSTN    in   asynchronous active-low reset
//   data    in   byte to send, sampled only in the accepting cycle
//   ready   in   send request, honoured only while idle
//   done    out  1 = idle / can accept, 0 = frame in progress (registered)
//   UART_TX out  serial line, idle high (registered)
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] data,
    input  logic       ready,
    output logic       done,
    output logic       UART_TX
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_done;
    logic               r_tx;
`ifdef UART_TX_PARITY_EN
    logic               r_par;
`endif

    logic               w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign done      = r_done;
    assign UART_TX   = r_tx;

    // The line value for the next bit is loaded on the same edge that ends
    // the current bit, so UART_TX always comes straight from a flop.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_done  <= 1'b1;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (ready) begin
                        r_shift <= data;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^data;
`endif
                        r_idx   <= 3'd0;
                        r_done  <= 1'b0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            // shift[1] becomes shift[0] on this edge
                            r_tx  <= r_shift[1];
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (w_bit_end) begin
                        // done rises on the edge that ends the stop bit; a
                        // ready held high is accepted on the very next edge
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_tx    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_done  <= 1'b1;
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
